// File: rtl/mem_bus_arbiter.sv
// Two-way arbiter sequencing fetch and load/store onto one mem_access unit.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of data priority.
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_done,
  output logic [7:0]  f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [7:0]  d_rdata,
  output logic        ma_en,
  output logic        ma_pc_data,
  output logic        ma_w_rd,
  output logic [15:0] ma_pc,
  output logic [15:0] ma_address,
  output logic [7:0]  ma_wdata,
  input  logic [7:0]  ma_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic [2:0] WLAST =
    3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_t     state, state_nxt;
  logic [2:0] wcnt, wcnt_nxt;
  logic       sel_f;
  logic       we_q;
  logic       f_win;

  logic take, own_f, own_we, run, fin;
  logic f_gnt_n, d_gnt_n, f_done_n, d_done_n;
  logic ma_en_n, ma_pc_data_n, ma_w_rd_n, busy_n;
  logic f_load, d_load;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // last_d resets to "fetch granted last", so data takes the first tie
  assign f_win = f_req && (!d_req || last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (take) begin
      last_d <= !f_win;
    end
  end
`else
  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign f_win = f_req && (!d_req || starve_cnt == SMAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!f_req || f_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SMAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      IDLE: begin
        if (f_req || d_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        wcnt_nxt  = '0;
        state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        if (wcnt == WLAST) state_nxt = DONE;
        else wcnt_nxt = wcnt + 1'b1;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are registered, so they are derived from the next state
  always_comb begin
    take   = (state == IDLE) && (f_req || d_req);
    own_f  = take ? f_win : sel_f;
    own_we = take ? d_we : we_q;
    run    = (state_nxt == ACCESS) || (state_nxt == WAIT);
    fin    = (state_nxt == DONE);

    f_gnt_n      = take && f_win;
    d_gnt_n      = take && !f_win;
    ma_en_n      = run;
    ma_pc_data_n = run && own_f;
    ma_w_rd_n    = run && !own_f && own_we;
    f_done_n     = fin && own_f;
    d_done_n     = fin && !own_f;
    f_load       = fin && own_f;
    d_load       = fin && !own_f && !own_we;
    busy_n       = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_f      <= 1'b0;
      we_q       <= 1'b0;
      f_gnt      <= 1'b0;
      d_gnt      <= 1'b0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      ma_en      <= 1'b0;
      ma_pc_data <= 1'b0;
      ma_w_rd    <= 1'b0;
      ma_pc      <= '0;
      ma_address <= '0;
      ma_wdata   <= '0;
      busy       <= 1'b0;
    end else begin
      f_gnt      <= f_gnt_n;
      d_gnt      <= d_gnt_n;
      f_done     <= f_done_n;
      d_done     <= d_done_n;
      ma_en      <= ma_en_n;
      ma_pc_data <= ma_pc_data_n;
      ma_w_rd    <= ma_w_rd_n;
      busy       <= busy_n;
      if (take) begin
        sel_f <= f_win;
        if (f_win) begin
          ma_pc <= f_addr;
        end else begin
          ma_address <= d_addr;
          ma_wdata   <= d_wdata;
          we_q       <= d_we;
        end
      end
      if (f_load) f_rdata <= ma_rdata;
      if (d_load) d_rdata <= ma_rdata;
    end
  end

endmodule
